// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the OTTER data-memory port arbiter.
package otter_mem_pkg;

    typedef enum logic {IDLE, WAIT} arb_state_t;
    typedef enum logic {OWN_IF, OWN_MEM} arb_owner_t;

    // funct3 size/sign codes carried on the port unchanged
    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;
    localparam logic [2:0] SZ_BU   = 3'b100;
    localparam logic [2:0] SZ_HU   = 3'b101;

    localparam int GNT_IF  = 0;
    localparam int GNT_MEM = 1;
    localparam int CNT_W   = 4;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational grant selection: MEM has priority unless its streak has starved IF.
module arb_grant_sel
    import otter_mem_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic             idle,
    input  logic             if_req,
    input  logic             mem_req,
    input  logic [CNT_W-1:0] streak,
    output logic [1:0]       grant
);

    localparam logic [CNT_W-1:0] STREAK_LIMIT = CNT_W'(MAX_STREAK);

    logic force_if;

    assign force_if = (streak == STREAK_LIMIT);

    always_comb begin
        grant = '0;
        if (idle) begin
            if (mem_req && !(if_req && force_if)) begin
                grant[GNT_MEM] = 1'b1;
            end else if (if_req) begin
                grant[GNT_IF] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch and the memory stage.
// Optional build macro ARB_PERF_CNT_EN adds saturating per-requester wait-cycle counters.
module mem_port_arbiter
    import otter_mem_pkg::*;
#(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic        ARB_CLOCK,
    input  logic        ARB_RESET_N,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic        IF_GNT,
    output logic        IF_RVALID,
    output logic [31:0] IF_RDATA,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    input  logic [31:0] MEM_ADDR,
    input  logic [31:0] MEM_WDATA,
    input  logic [2:0]  MEM_SIZE,
    output logic        MEM_GNT,
    output logic        MEM_RVALID,
    output logic [31:0] MEM_RDATA,
    output logic [31:0] P_ADDR,
    output logic [31:0] P_WDATA,
    output logic [2:0]  P_SIZE,
    output logic        P_RDEN,
    output logic        P_WE,
    input  logic [31:0] P_RDATA
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] PERF_IF_WAIT,
    output logic [31:0] PERF_MEM_WAIT
`endif
);

    localparam logic [CNT_W-1:0] CNT_INIT     = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] STREAK_LIMIT = CNT_W'(MAX_STREAK);

    arb_state_t       state;
    arb_owner_t       owner;
    logic             owner_we;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] streak;
    logic [1:0]       grant;
    logic             idle;

    // Gating with reset keeps grants and strobes quiet while reset is held.
    assign idle = (state == IDLE) && ARB_RESET_N;

    arb_grant_sel #(
        .MAX_STREAK (MAX_STREAK)
    ) u_grant_sel (
        .idle    (idle),
        .if_req  (IF_REQ),
        .mem_req (MEM_REQ),
        .streak  (streak),
        .grant   (grant)
    );

    assign IF_GNT  = grant[GNT_IF];
    assign MEM_GNT = grant[GNT_MEM];

    always_comb begin
        P_ADDR  = '0;
        P_WDATA = '0;
        P_SIZE  = '0;
        P_RDEN  = 1'b0;
        P_WE    = 1'b0;
        if (grant[GNT_MEM]) begin
            P_ADDR  = MEM_ADDR;
            P_WDATA = MEM_WDATA;
            P_SIZE  = MEM_SIZE;
            P_WE    = MEM_WE;
            P_RDEN  = !MEM_WE;
        end else if (grant[GNT_IF]) begin
            P_ADDR  = IF_ADDR;
            P_SIZE  = SZ_WORD;
            P_RDEN  = 1'b1;
        end
    end

    always_ff @(posedge ARB_CLOCK or negedge ARB_RESET_N) begin
        if (!ARB_RESET_N) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            owner_we   <= 1'b0;
            wait_cnt   <= '0;
            streak     <= '0;
            IF_RVALID  <= 1'b0;
            IF_RDATA   <= '0;
            MEM_RVALID <= 1'b0;
            MEM_RDATA  <= '0;
        end else begin
            IF_RVALID  <= 1'b0;
            MEM_RVALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        owner    <= grant[GNT_MEM] ? OWN_MEM : OWN_IF;
                        owner_we <= grant[GNT_MEM] && MEM_WE;
                        wait_cnt <= CNT_INIT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= IDLE;
                        if (owner == OWN_IF) begin
                            IF_RVALID <= 1'b1;
                            IF_RDATA  <= P_RDATA;
                        end else begin
                            MEM_RVALID <= 1'b1;
                            MEM_RDATA  <= owner_we ? '0 : P_RDATA;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Streak only grows while IF is actually being passed over.
            if (grant[GNT_IF] || !IF_REQ) begin
                streak <= '0;
            end else if (grant[GNT_MEM] && (streak != STREAK_LIMIT)) begin
                streak <= streak + 1'b1;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge ARB_CLOCK or negedge ARB_RESET_N) begin
        if (!ARB_RESET_N) begin
            PERF_IF_WAIT  <= '0;
            PERF_MEM_WAIT <= '0;
        end else begin
            if (IF_REQ && !IF_GNT && (PERF_IF_WAIT != '1)) begin
                PERF_IF_WAIT <= PERF_IF_WAIT + 1'b1;
            end
            if (MEM_REQ && !MEM_GNT && (PERF_MEM_WAIT != '1)) begin
                PERF_MEM_WAIT <= PERF_MEM_WAIT + 1'b1;
            end
        end
    end
`endif

endmodule
